// File: rtl/intc8.sv
// Eight-source priority interrupt controller: edge-latched pending requests,
// software mask, one vectored request at a time with ack/eoi handshake.
module intc8 #(
    parameter int NSRC = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] src,
    input  logic       mask_we,
    input  logic [7:0] mask_wdata,
    input  logic       ack,
    input  logic       eoi,
    output logic       interrupt,
    output logic [2:0] irq,
    output logic [7:0] mask,
    output logic [7:0] pending,
    output logic       in_service
);
    localparam logic [8:0] IMPL_W = (9'd1 << NSRC) - 9'd1;
    localparam logic [7:0] IMPL   = IMPL_W[7:0];

    typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

    state_t     state;
    logic [7:0] src_q;
    logic [7:0] rise;
    logic [7:0] eligible;
    logic [7:0] clr;
    logic [7:0] pending_next;
    logic [2:0] sel;

    // Index 0 wins: scan from the top so the lowest set bit is written last.
    function automatic logic [2:0] lowest_set(input logic [7:0] v);
        logic [2:0] s;
        s = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) s = 3'(i);
        end
        return s;
    endfunction

    always_comb begin
        rise     = src & ~src_q & IMPL;
        eligible = pending & ~mask;
        sel      = lowest_set(eligible);
        clr      = 8'd0;
        if (state == REQ && ack) clr[irq] = 1'b1;
        // A fresh edge in the acknowledge cycle must survive the clear.
        pending_next = (pending & ~clr) | rise;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            interrupt  <= 1'b0;
            in_service <= 1'b0;
            irq        <= 3'd0;
            pending    <= 8'd0;
            src_q      <= 8'd0;
            mask       <= 8'hFF;
        end else begin
            src_q   <= src;
            pending <= pending_next;
            if (mask_we) mask <= mask_wdata;

            case (state)
                IDLE: begin
                    if (eligible != 8'd0) begin
                        state     <= REQ;
                        irq       <= sel;
                        interrupt <= 1'b1;
                    end
                end
                REQ: begin
                    if (ack) begin
                        state      <= SERVICE;
                        interrupt  <= 1'b0;
                        in_service <= 1'b1;
                    end
                end
                SERVICE: begin
                    if (eoi) begin
                        state      <= IDLE;
                        in_service <= 1'b0;
                    end
                end
                default: begin
                    state      <= IDLE;
                    interrupt  <= 1'b0;
                    in_service <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_intc8.sv
// Bench for intc8: directed scenarios plus randomized traffic, checked
// against a cycle-level behavioural model of the controller's rules.
module tb_intc8;
    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] src;
    logic       mask_we;
    logic [7:0] mask_wdata;
    logic       ack;
    logic       eoi;
    logic       interrupt;
    logic [2:0] irq;
    logic [7:0] mask;
    logic [7:0] pending;
    logic       in_service;

    int n_cmp = 0;
    int n_err = 0;

    // Model state: 0 = idle, 1 = request presented, 2 = handler running.
    int       m_st;
    int       m_irq;
    bit [7:0] m_pend;
    bit [7:0] m_mask;
    bit [7:0] m_srcq;

    intc8 #(.NSRC(8)) dut (
        .clock(clock), .reset(reset), .src(src), .mask_we(mask_we),
        .mask_wdata(mask_wdata), .ack(ack), .eoi(eoi), .interrupt(interrupt),
        .irq(irq), .mask(mask), .pending(pending), .in_service(in_service)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_st = 0; m_irq = 0; m_pend = 8'h00; m_mask = 8'hFF; m_srcq = 8'h00;
    endtask

    // Next state from the current model state and the inputs sampled at the edge.
    task automatic model_step();
        bit [7:0] elig;
        int       nst;
        elig = m_pend & ~m_mask;
        nst  = m_st;
        if (m_st == 0 && elig != 0) begin
            nst = 1;
            for (int i = 7; i >= 0; i--) if (elig[i]) m_irq = i;
        end else if (m_st == 1 && ack) begin
            nst = 2;
            m_pend[m_irq] = 1'b0;
        end else if (m_st == 2 && eoi) begin
            nst = 0;
        end
        m_pend = m_pend | (src & ~m_srcq);
        if (mask_we) m_mask = mask_wdata;
        m_srcq = src;
        m_st   = nst;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".interrupt"}, 8'(interrupt), 8'(m_st == 1));
        check({tag, ".in_service"}, 8'(in_service), 8'(m_st == 2));
        check({tag, ".mask"}, mask, m_mask);
        check({tag, ".pending"}, pending, m_pend);
        if (m_st == 1) check({tag, ".irq"}, 8'(irq), 8'(m_irq));
    endtask

    task automatic cycle(input logic [7:0] s, input logic mw, input logic [7:0] md,
                         input logic a, input logic e, input string tag);
        src = s; mask_we = mw; mask_wdata = md; ack = a; eoi = e;
        model_step();
        @(posedge clock);
        #1;
        check_all(tag);
    endtask

    initial begin
        reset = 1'b1; src = 8'h00; mask_we = 1'b0; mask_wdata = 8'h00; ack = 1'b0; eoi = 1'b0;
        model_reset();
        #3;
        check("rst.interrupt", 8'(interrupt), 8'h00);
        check("rst.irq", 8'(irq), 8'h00);
        check("rst.in_service", 8'(in_service), 8'h00);
        check("rst.mask", mask, 8'hFF);
        check("rst.pending", pending, 8'h00);
        #3 reset = 1'b0;
        @(posedge clock); #1;

        // Single source 5
        cycle(8'h00, 1, 8'h00, 0, 0, "t1.mask");
        cycle(8'h20, 0, 8'h00, 0, 0, "t1.edge");
        check("t1.pend20", pending, 8'h20);
        cycle(8'h00, 0, 8'h00, 0, 0, "t1.req");
        check("t1.int", 8'(interrupt), 8'h01);
        check("t1.irq5", 8'(irq), 8'h05);
        cycle(8'h00, 0, 8'h00, 1, 0, "t1.ack");
        check("t1.ack_pend", pending, 8'h00);
        check("t1.ack_isr", 8'(in_service), 8'h01);
        cycle(8'h00, 0, 8'h00, 0, 1, "t1.eoi");

        // Simultaneous 6 and 2
        cycle(8'h44, 0, 8'h00, 0, 0, "t2.edge");
        cycle(8'h00, 0, 8'h00, 0, 0, "t2.req");
        check("t2.irq2", 8'(irq), 8'h02);
        cycle(8'h00, 0, 8'h00, 1, 0, "t2.ack");
        cycle(8'h00, 0, 8'h00, 0, 1, "t2.eoi");
        check("t2.idle_gap", 8'(interrupt), 8'h00);
        cycle(8'h00, 0, 8'h00, 0, 0, "t2.req6");
        check("t2.irq6", 8'(irq), 8'h06);
        cycle(8'h00, 0, 8'h00, 1, 0, "t2.ack6");
        cycle(8'h00, 0, 8'h00, 0, 1, "t2.eoi6");

        // Masked source 3
        cycle(8'h00, 1, 8'h08, 0, 0, "t3.mask");
        cycle(8'h08, 0, 8'h00, 0, 0, "t3.edge");
        cycle(8'h00, 0, 8'h00, 0, 0, "t3.hold");
        check("t3.masked_int", 8'(interrupt), 8'h00);
        check("t3.pend3", pending, 8'h08);
        cycle(8'h00, 1, 8'h00, 0, 0, "t3.unmask");
        check("t3.not_yet", 8'(interrupt), 8'h00);
        cycle(8'h00, 0, 8'h00, 0, 0, "t3.req");
        check("t3.irq3", 8'(irq), 8'h03);
        cycle(8'h00, 0, 8'h00, 1, 0, "t3.ack");
        cycle(8'h00, 0, 8'h00, 0, 1, "t3.eoi");

        // Held vector under higher-priority arrival, set-wins on ack
        cycle(8'h10, 0, 8'h00, 0, 0, "t4.edge");
        cycle(8'h00, 0, 8'h00, 0, 0, "t4.req");
        cycle(8'h01, 0, 8'h00, 0, 0, "t4.src0");
        check("t4.irq_held", 8'(irq), 8'h04);
        cycle(8'h10, 0, 8'h00, 1, 0, "t4.ack_reedge");
        check("t4.pend4_kept", 8'(pending[4]), 8'h01);
        cycle(8'h00, 0, 8'h00, 0, 1, "t4.eoi");
        cycle(8'h00, 0, 8'h00, 0, 0, "t4.req0");
        check("t4.irq0", 8'(irq), 8'h00);
        cycle(8'h00, 0, 8'h00, 1, 0, "t4.ack0");
        cycle(8'h00, 0, 8'h00, 0, 1, "t4.eoi0");
        cycle(8'h00, 0, 8'h00, 0, 0, "t4.req4");
        cycle(8'h00, 0, 8'h00, 1, 0, "t4.ack4");
        cycle(8'h00, 0, 8'h00, 0, 1, "t4.eoi4");

        // Stray ack/eoi, then async reset in REQ
        cycle(8'h00, 0, 8'h00, 1, 0, "t5.ack_idle");
        cycle(8'h02, 0, 8'h00, 0, 1, "t5.eoi_idle");
        cycle(8'h00, 0, 8'h00, 0, 1, "t5.req");
        cycle(8'h00, 0, 8'h00, 0, 1, "t5.eoi_req");
        check("t5.still_req", 8'(interrupt), 8'h01);
        #2 reset = 1'b1;
        #1;
        check("t5.async_int", 8'(interrupt), 8'h00);
        check("t5.async_mask", mask, 8'hFF);
        check("t5.async_pend", pending, 8'h00);
        model_reset();
        #1 reset = 1'b0;
        @(posedge clock); #1;

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            logic [7:0] s;
            s = ($urandom_range(0, 3) == 0) ? 8'($urandom) : src;
            cycle(s, ($urandom_range(0, 7) == 0), 8'($urandom & $urandom),
                  ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0), "rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/intc8.md
# intc8

Eight-source priority interrupt controller that drives the `interrupt`/`irq[2:0]` inputs of the MCU0 core. It latches rising edges from peripheral request lines and applies a software-writable mask. It presents one vectored request at a time to the CPU and tracks acknowledge and end-of-interrupt (IRET), so requests are neither lost nor re-delivered.

## Interface
- `NSRC`, 8, number of implemented source lines (1..8); `src[7:NSRC]` are ignored and their pending bits read 0.

- `clock`  in  1  system clock; all state updates on posedge.
- `reset`  in  1  asynchronous, active-high; forces all state to reset values immediately.
- `src`  in  8  peripheral request lines; rising edge = new request.
- `mask_we`  in  1  write strobe for mask register.
- `mask_wdata`  in  8  new mask value; bit=1 disables that source.
- `ack`  in  1  one-cycle pulse: CPU has taken the interrupt (`LR=PC`, `PC=irq`).
- `eoi`  in  1  one-cycle pulse: CPU executed IRET.
- `interrupt`  out  1  request to CPU.
- `irq`  out  3  vector index of the presented request.
- `mask`  out  8  current mask register.
- `pending`  out  8  latched, not yet acknowledged requests.
- `in_service`  out  1  the CPU is executing a handler.

## Operation
- `src_q` is a registered copy of `src`. An edge for source `i` is `src[i] & ~src_q[i]`, evaluated at each posedge.
- `pending[i]` sets on an edge and clears only when source `i` is acknowledged.
  - If an edge and the clear for the same `i` occur in one cycle, set wins and `pending[i]` stays 1.
  - Masking never clears `pending`. A masked edge is still latched and fires once unmasked.
- `eligible = pending & ~mask`. Index 0 has the highest priority. `sel` is the lowest set index of `eligible`.
- FSM with states IDLE, REQ and SERVICE:
  - IDLE: if `eligible != 0`, go to REQ and latch `irq <= sel`.
  - REQ: `interrupt=1` and `irq` is held stable. If `ack`, clear `pending[irq]` and go to SERVICE. Mask changes or higher-priority arrivals during REQ do not alter `irq` and do not withdraw the request.
  - SERVICE: `interrupt=0` and `in_service=1`. If `eoi`, go to IDLE. Handlers are not nested, so new requests only accumulate in `pending`.
- `ack` is ignored outside REQ. `eoi` is ignored outside SERVICE.
- `mask_we` loads `mask <= mask_wdata` at the posedge. It is legal in any state.
- `interrupt` is a registered output, equal to (state == REQ). `in_service` equals (state == SERVICE).

## Timing
- Reset values:
  - `state=IDLE`, `interrupt=0`, `irq=0`, `in_service=0`.
  - `pending=0`, `src_q=0`, `mask=8'hFF` (everything masked).
- Because `src_q` resets to 0, a line that is already high at reset release registers an edge at the first posedge.
- Latency from `src[i]` rising (sampled at edge k, with the source unmasked and the FSM idle):
  - `pending[i]=1` after edge k.
  - `interrupt=1` with `irq=i` after edge k+1.
- Acknowledge: `ack` is sampled at edge a. After edge a, `interrupt=0`, `in_service=1` and `pending[irq]=0`.
- End of interrupt: `eoi` is sampled at edge e, and the FSM is in IDLE after edge e. A further eligible request re-asserts `interrupt` after edge e+1, so IDLE always lasts at least one cycle.
- A mask write at edge w affects `eligible` from cycle w+1.
- Asserting `reset` mid-request drops `interrupt` asynchronously and discards all pending requests.

## Test plan
- Reset, write `mask=8'h00`, pulse `src[5]` high: `pending=8'h20` after 1 clock, then `interrupt=1, irq=5` after the next clock. Pulse `ack`: `interrupt=0`, `in_service=1`, `pending=0`. Pulse `eoi`: back to idle.
- Raise `src[6]` and `src[2]` in the same cycle with `mask=0`: `irq=2` first. After `ack`/`eoi`, `irq=6` is presented one idle cycle later.
- With `mask=8'h08`, raise `src[3]`: `pending[3]=1` and `interrupt` stays 0. Write `mask=0`: `interrupt=1, irq=3` appears 2 clocks after the write.
- In REQ with `irq=4`, raise `src[0]`: `irq` stays 4 until `ack`. Re-edge `src[4]` in the `ack` cycle: `pending[4]` stays 1.
- Pulse `ack` in IDLE and `eoi` in REQ: no state change. Assert `reset` async while in REQ: `interrupt=0` and `mask=8'hFF` before the next posedge.
